multdiv: RTL and testbench
==========================

MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Parameter: ITER, WIDTH, number of iteration cycles per operation.
REQ-003 clock  input  1  Single clock; all state updates on its rising edge.
REQ-004 ctrl_reset_n  input  1  Reset, asynchronous and active-low.
REQ-005 ctrl_MULT  input  1  Start pulse for a signed multiply; sampled on the rising edge.
REQ-006 ctrl_DIV  input  1  Start pulse for a signed divide; sampled on the rising edge.
REQ-007 data_operandA  input  WIDTH  Multiplicand or dividend, taken from regfile port A; sampled only on a start edge.
REQ-008 data_operandB  input  WIDTH  Multiplier or divisor, taken from regfile port B; sampled only on a start edge.
REQ-009 data_result  output  WIDTH  Product (low WIDTH bits) or quotient, sent to regfile writeback.
REQ-010 data_exception  output  1  Overflow or divide-by-zero flag; valid when data_resultRDY is high.
REQ-011 data_resultRDY  output  1  Single-cycle pulse marking data_result and data_exception valid.

Function
REQ-012 States SHALL be IDLE, MUL, DIV and DONE.
REQ-013 Start edge (E0) from any state:
- latch both operands
- clear the iteration counter
- go to MUL if ctrl_MULT=1, otherwise to DIV if ctrl_DIV=1.
REQ-014 If ctrl_MULT and ctrl_DIV are both high on the same edge, the block SHALL perform a multiply.
REQ-015 A start during MUL, DIV or DONE SHALL abort the current operation without asserting data_resultRDY and restart from the new operands.
REQ-016 MUL and DIV SHALL each perform exactly ITER iterations, on edges E1..E32 when ITER=32, then go to DONE.
REQ-017 In DONE, data_resultRDY=1 for exactly one cycle, starting after E32; the next edge returns the FSM to IDLE.
REQ-018 Fixed latency: 32 edges from start to data_resultRDY, independent of operand values.
REQ-019 Multiply: radix-2 shift-add over magnitudes with the sign applied at the end, or Booth; the result SHALL be identical in either case.
REQ-020 Multiply: data_result = low 32 bits of the 64-bit signed product.
REQ-021 Multiply: data_exception=1 iff the product does not fit in signed 32 bits, i.e. the upper 33 bits are not all equal.
REQ-022 Divide: restoring division over magnitudes; the quotient SHALL truncate toward zero and be negated iff the operand signs differ; the remainder is discarded.
REQ-023 Divide by zero: data_result=0 and data_exception=1, with full latency still applied.
REQ-024 Divide 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
REQ-025 data_result and data_exception SHALL hold their last values until the next DONE; they are not cleared on start.
REQ-026 Operand inputs SHALL be ignored outside start edges, so the regfile read ports may change freely while the block is busy.

Reset
REQ-027 Asserting ctrl_reset_n low SHALL immediately force:
- FSM to IDLE
- counter to 0
- data_result=0
- data_exception=0
- data_resultRDY=0.
REQ-028 Reset mid-operation SHALL discard the operation; no data_resultRDY pulse follows.
REQ-029 Start pulses SHALL be ignored while ctrl_reset_n=0; the first start honoured is on the first edge after deassertion.

Structure
REQ-030 Package multdiv_pkg SHALL hold the WIDTH default, the state encoding (IDLE/MUL/DIV/DONE) and the constant INT_MIN=0x80000000.
REQ-031 A single sub-module, addsub33, SHALL provide a 33-bit add/subtract with a subtract control; it is shared by the multiply-accumulate and divide-trial-subtract datapaths.
REQ-032 Iteration counter width SHALL be $clog2(ITER)+1 bits.
REQ-033 No combinational path SHALL exist from any input to data_resultRDY.

Verification
REQ-034 Multiply 7 x -6 -> data_resultRDY 32 edges after start, data_result=0xFFFFFFD6, data_exception=0.
REQ-035 Multiply 0x00010000 x 0x00010000 -> data_result=0x00000000, data_exception=1; also 0x7FFFFFFF x 1 -> 0x7FFFFFFF, data_exception=0.
REQ-036 Divide -7 / 2 -> data_result=0xFFFFFFFD (-3), data_exception=0; divide 100 / 0 -> data_result=0, data_exception=1.
REQ-037 Divide 0x80000000 / 0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
REQ-038 Start multiply 3x3, then at edge 10 start divide 81/9 -> no pulse for the multiply; a single pulse 32 edges after the divide start with data_result=9.
REQ-039 Drive ctrl_reset_n low at edge 15 of a multiply -> outputs zero immediately, no data_resultRDY pulse within 40 following cycles; a fresh start after release completes normally.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the iterative signed multiply/divide unit.
//   WIDTH_DEF : default operand/result width
//   state_e   : FSM state encoding (IDLE/MUL/DIV/DONE)
//   INT_MIN   : most negative 32-bit signed value
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: start/operand/result bundle between the pipeline and multdiv.
//   master : drives ctrl_MULT, ctrl_DIV, data_operandA/B; sees results
//   slave  : the multdiv unit; drives data_result, data_exception, data_resultRDY
interface multdiv_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/addsub33.sv
// addsub33: combinational add/subtract shared by the multiply accumulate
// and the divide trial subtract.
//   a_i, b_i : operands
//   sub_i    : 1 = a_i - b_i, 0 = a_i + b_i
//   sum_o    : result, same width as the operands (carry/borrow dropped)
module addsub33
  import multdiv_pkg::*;
#(
  parameter int W = WIDTH_DEF + 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);
  // two's-complement subtract: invert b and inject the +1 as carry-in
  assign sum_o = a_i + (b_i ^ {W{sub_i}}) + W'(sub_i);
endmodule

// File: rtl/multdiv.sv
// multdiv: fixed-latency iterative signed multiply / divide.
//   clock          : rising-edge clock
//   ctrl_reset_n   : asynchronous active-low reset
//   bus (slave)    : ctrl_MULT/ctrl_DIV start pulses, data_operandA/B,
//                    data_result, data_exception, data_resultRDY
// A start edge latches operand magnitudes and the result sign. ITER
// iterations follow (shift-add for multiply, restoring for divide), the
// final one writing the signed result and a one-cycle data_resultRDY.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic     clock,
  input  logic     ctrl_reset_n,
  multdiv_if.slave bus
);
  localparam int CW = $clog2(ITER) + 1;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // magnitude of a signed value; SMIN maps to 2^(WIDTH-1) read unsigned
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;   // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;    // multiplier shifting out / dividend->quotient
  logic [WIDTH-1:0] b_q;     // multiplicand or divisor magnitude
  logic             neg_q;   // operand signs differ
  logic             ovf_q;   // divide SMIN / -1
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;

  logic start;
  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  logic last;
  assign last = (cnt_q == CW'(ITER - 1));

  // shared adder input steering
  logic [WIDTH:0] add_a, add_b, add_s;
  logic           add_sub;

  always_comb begin
    add_a   = {1'b0, acc_q};
    add_b   = lo_q[0] ? {1'b0, b_q} : '0;
    add_sub = 1'b0;
    if (state_q == DIV) begin
      add_a   = {acc_q, lo_q[WIDTH-1]};
      add_b   = {1'b0, b_q};
      add_sub = 1'b1;
    end
  end

  addsub33 #(.W(WIDTH + 1)) u_addsub (
    .a_i   (add_a),
    .b_i   (add_b),
    .sub_i (add_sub),
    .sum_o (add_s)
  );

  // multiply: post-step 2W-bit magnitude product and its signed form
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               mul_exc;
  assign prod    = {add_s, lo_q[WIDTH-1:1]};
  assign prod_s  = neg_q ? -prod : prod;
  // fits in signed WIDTH bits only if the top WIDTH+1 bits are all equal
  assign mul_exc = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));

  // divide: trial subtract succeeds when the difference is non-negative
  logic             q_bit;
  logic [WIDTH-1:0] rem_d, quo_d, quo_s;
  logic             dz;
  assign q_bit = ~add_s[WIDTH];
  // remainder stays below the divisor, so WIDTH bits always suffice
  assign rem_d = q_bit ? add_s[WIDTH-1:0] : add_a[WIDTH-1:0];
  assign quo_d = {lo_q[WIDTH-2:0], q_bit};
  assign quo_s = neg_q ? -quo_d : quo_d;
  assign dz    = (b_q == '0);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else if (start) begin
      // a start always wins, aborting whatever was in flight
      state_q <= bus.ctrl_MULT ? MUL : DIV;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= bus.ctrl_MULT ? mag(bus.data_operandB) : mag(bus.data_operandA);
      b_q     <= bus.ctrl_MULT ? mag(bus.data_operandA) : mag(bus.data_operandB);
      neg_q   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      ovf_q   <= ~bus.ctrl_MULT && (bus.data_operandA == SMIN) &&
                 (bus.data_operandB == '1);
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: rdy_q <= 1'b0;
        MUL: begin
          acc_q <= add_s[WIDTH:1];
          lo_q  <= {add_s[0], lo_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q  <= DONE;
            result_q <= prod_s[WIDTH-1:0];
            exc_q    <= mul_exc;
            rdy_q    <= 1'b1;
          end
        end
        DIV: begin
          acc_q <= rem_d;
          lo_q  <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q  <= DONE;
            result_q <= dz ? '0 : quo_s;
            exc_q    <= dz | ovf_q;
            rdy_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed vectors for multdiv with hand-computed results.
module tb_multdiv;
  import multdiv_pkg::*;

  logic clock;
  logic rst_n;
  int   nchk = 0;
  int   nerr = 0;
  logic [31:0] last_res;

  multdiv_if #(.WIDTH(32)) bus ();

  multdiv #(.WIDTH(32), .ITER(32)) dut (
    .clock        (clock),
    .ctrl_reset_n (rst_n),
    .bus          (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // one-edge start pulse; operands are scrambled afterwards
  task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // n cycles with no ready pulse expected
  task automatic quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] er, input logic ee);
    int lat = 0;
    while (!bus.data_resultRDY && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd32);
    chk({tag, "_res"}, bus.data_result, er);
    chk({tag, "_exc"}, 32'(bus.data_exception), 32'(ee));
    @(posedge clock);
    #1;
    chk({tag, "_pulse"}, 32'(bus.data_resultRDY), 32'd0);
    last_res = er;
  endtask

  task automatic do_op(input string tag, input bit m, input bit d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee);
    start(m, d, a, b);
    chk({tag, "_hold"}, bus.data_result, last_res);
    finish_op(tag, er, ee);
  endtask

  initial begin
    rst_n             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    last_res          = '0;

    // reset, with a start held during it that must be ignored
    #3 rst_n = 1'b0;
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    #1;
    chk("rst_res", bus.data_result, 32'd0);
    chk("rst_exc", 32'(bus.data_exception), 32'd0);
    chk("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    rst_n         = 1'b1;
    quiet("rst_start_ignored", 40);

    // multiply
    do_op("m7xm6",    1, 0, 32'd7,        32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
    do_op("m64k_sq",  1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    do_op("mmax_x1",  1, 0, 32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 1'b0);
    do_op("mmin_xm1", 1, 0, INT_MIN,      32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_op("mmin_x1",  1, 0, INT_MIN,      32'd1,        32'h8000_0000, 1'b0);
    do_op("mm5_sq",   1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25,        1'b0);
    do_op("both",     1, 1, 32'd6,        32'd3,        32'd18,        1'b0);

    // divide
    do_op("dm7_2",    0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
    do_op("d7_m2",    0, 1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    do_op("d100_0",   0, 1, 32'd100,      32'd0,        32'd0,         1'b1);
    do_op("dmin_m1",  0, 1, INT_MIN,      32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_op("d0_5",     0, 1, 32'd0,        32'd5,        32'd0,         1'b0);
    do_op("dmax_7",   0, 1, 32'h7FFF_FFFF, 32'd7,        32'h1249_2492, 1'b0);

    // abort: multiply 3x3, divide 81/9 started on edge 10
    start(1, 0, 32'd3, 32'd3);
    quiet("abort_early", 9);
    start(0, 1, 32'd81, 32'd9);
    finish_op("abort_div", 32'd9, 1'b0);

    // reset in the middle of a multiply
    start(1, 0, 32'd5, 32'd5);
    quiet("mid_pre", 14);
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_res", bus.data_result, 32'd0);
    chk("mid_exc", 32'(bus.data_exception), 32'd0);
    chk("mid_rdy", 32'(bus.data_resultRDY), 32'd0);
    @(negedge clock);
    rst_n    = 1'b1;
    last_res = '0;
    quiet("mid_no_pulse", 40);
    do_op("post_rst", 1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
